// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared MD5 widths, state encoding and block field positions
package md5_pkg;

    localparam int DIGEST_W = 128;
    localparam int BLOCK_W  = 512;
    localparam int MSG_W    = 64;
    localparam int LEN_W    = 7;
    localparam int MAX_LEN  = 64;

    // Candidate message occupies the first 64-bit word; bit length sits in the last word.
    localparam int MSG_MSB  = BLOCK_W - 1;
    localparam int MSG_LSB  = BLOCK_W - MSG_W;
    localparam int LENF_MSB = 63;
    localparam int LENF_LSB = 0;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FOUND = 2'd2
    } state_t;

    typedef struct packed {
        logic [MSG_W-1:0] message;
        logic [LEN_W-1:0] length;
    } match_entry_t;

endpackage

// File: rtl/md5_match_fifo.sv
// rtl/md5_match_fifo.sv - synchronous match FIFO, push accepted when full if popping same cycle
module md5_match_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 71
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero when empty so the outputs are clean after reset.
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/md5_match_collector.sv
// rtl/md5_match_collector.sv - compares pipeline digests to a target and queues recovered messages
module md5_match_collector
    import md5_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                target_load,
    input  logic [DIGEST_W-1:0] target_hash,
    input  logic                stop_on_first,
    input  logic                hash_valid,
    input  logic [DIGEST_W-1:0] hash,
    input  logic [BLOCK_W-1:0]  block,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MSG_W-1:0]    out_message,
    output logic [LEN_W-1:0]    out_length,
    output logic [1:0]          state,
    output logic [CNT_W-1:0]    checked_count,
    output logic [7:0]          match_count,
    output logic                overflow,
    output logic                bad_length
);

    function automatic logic [MSG_W-1:0] recover_message(input logic [MSG_W-1:0] word,
                                                         input logic [LEN_W-1:0] len);
        if (len == '0) begin
            return '0;
        end
        return word >> (LEN_W'(MAX_LEN) - len);
    endfunction

    state_t              state_q, state_d;
    logic [DIGEST_W-1:0] target_q;
    logic                stop_q;

    logic                s1_hit;
    logic                s1_bad;
    logic [LEN_W-1:0]    s1_len;
    logic [MSG_W-1:0]    s1_msg;

    logic [MSG_W-1:0]    len_field;
    logic                blk_bad;
    logic                cmp_en;
    logic                stage2_go;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drop;
    match_entry_t        head;
    logic                unused_block_bits;

    assign len_field = block[LENF_MSB:LENF_LSB];
    assign blk_bad   = (len_field > MSG_W'(MAX_LEN));
    assign unused_block_bits = ^block[MSG_LSB-1:LENF_MSB+1];

    // A target_load in the same cycle cancels both the new compare and the one in flight.
    assign cmp_en    = (state_q == ST_ARMED) && hash_valid && !target_load;
    assign stage2_go = s1_hit && (state_q == ST_ARMED) && !target_load;
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = stage2_go && !s1_bad && (!fifo_full || fifo_pop);
    assign drop      = stage2_go && !s1_bad && fifo_full && !fifo_pop;

    always_comb begin
        state_d = state_q;
        if (target_load) begin
            state_d = ST_ARMED;
        end else if (stage2_go && stop_q) begin
            state_d = ST_FOUND;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            target_q      <= '0;
            stop_q        <= 1'b0;
            checked_count <= '0;
            match_count   <= '0;
            overflow      <= 1'b0;
            bad_length    <= 1'b0;
            s1_hit        <= 1'b0;
            s1_bad        <= 1'b0;
            s1_len        <= '0;
            s1_msg        <= '0;
        end else begin
            state_q <= state_d;
            if (target_load) begin
                target_q      <= target_hash;
                stop_q        <= stop_on_first;
                checked_count <= '0;
                match_count   <= '0;
                overflow      <= 1'b0;
                bad_length    <= 1'b0;
            end else begin
                if ((state_q == ST_ARMED) && hash_valid) begin
                    checked_count <= checked_count + CNT_W'(1);
                end
                if (stage2_go) begin
                    if (match_count != 8'hff) begin
                        match_count <= match_count + 8'd1;
                    end
                    if (s1_bad) begin
                        bad_length <= 1'b1;
                    end
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
            s1_hit <= cmp_en && (hash == target_q);
            s1_bad <= blk_bad;
            s1_len <= len_field[LEN_W-1:0];
            s1_msg <= recover_message(block[MSG_MSB:MSG_LSB], len_field[LEN_W-1:0]);
        end
    end

    md5_match_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(match_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({s1_msg, s1_len}),
        .pop       (fifo_pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign out_message = head.message;
    assign out_length  = head.length;
    assign state       = state_q;

endmodule

// File: tb/tb_md5_match_collector.sv
// tb/tb_md5_match_collector.sv - scoreboard bench for md5_match_collector
module tb_md5_match_collector;

    localparam logic [127:0] ABC_HASH = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [63:0]  ABC_WORD = 64'h6162638000000000;

    logic         clk = 1'b0;
    logic         rst;
    logic         target_load;
    logic [127:0] target_hash;
    logic         stop_on_first;
    logic         hash_valid;
    logic [127:0] hash;
    logic [511:0] block;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_message;
    logic [6:0]   out_length;
    logic [1:0]   state;
    logic [47:0]  checked_count;
    logic [7:0]   match_count;
    logic         overflow;
    logic         bad_length;

    typedef struct {
        logic [63:0] msg;
        logic [6:0]  len;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    md5_match_collector #(
        .FIFO_DEPTH (4),
        .CNT_W      (48)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .target_load   (target_load),
        .target_hash   (target_hash),
        .stop_on_first (stop_on_first),
        .hash_valid    (hash_valid),
        .hash          (hash),
        .block         (block),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_message   (out_message),
        .out_length    (out_length),
        .state         (state),
        .checked_count (checked_count),
        .match_count   (match_count),
        .overflow      (overflow),
        .bad_length    (bad_length)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_entry: got msg 0x%0h len %0d expected none", out_message, out_length);
            end else begin
                e = exp_q.pop_front();
                chk("fifo_message", out_message, e.msg);
                chk("fifo_length", 64'(out_length), 64'(e.len));
            end
        end
    end

    function automatic logic [511:0] mk_block(input logic [63:0] word, input logic [63:0] lenf);
        return {word, 384'b0, lenf};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] t, input logic stop);
        target_hash   = t;
        stop_on_first = stop;
        target_load   = 1'b1;
        tick();
        target_load   = 1'b0;
    endtask

    task automatic drive(input logic [127:0] h, input logic [63:0] word, input logic [63:0] lenf);
        hash_valid = 1'b1;
        hash       = h;
        block      = mk_block(word, lenf);
    endtask

    task automatic expect_entry(input logic [63:0] m, input logic [6:0] l);
        exp_t e;
        e.msg = m;
        e.len = l;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
            tick();
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        tick();
        tick();
        chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; target_load = 1'b0; target_hash = '0; stop_on_first = 1'b0;
        hash_valid = 1'b0; hash = '0; block = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_message", out_message, 64'd0);
        chk("rst_out_length", 64'(out_length), 64'd0);
        chk("rst_checked", 64'(checked_count), 64'd0);
        chk("rst_match", 64'(match_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_bad_length", 64'(bad_length), 64'd0);

        // IDLE ignores results even when the digest equals the reset target.
        drive(128'h0, ABC_WORD, 64'd24);
        tick();
        hash_valid = 1'b0;
        tick();
        tick();
        chk("idle_checked", 64'(checked_count), 64'd0);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // 100 misses then the "abc" block.
        load(ABC_HASH, 1'b0);
        chk("load_state", 64'(state), 64'd1);
        for (int i = 0; i < 100; i++) begin
            drive(ABC_HASH ^ 128'(i + 1), ABC_WORD, 64'd24);
            tick();
        end
        drive(ABC_HASH, ABC_WORD, 64'd24);
        expect_entry(64'h616263, 7'd24);
        tick();
        hash_valid = 1'b0;
        chk("abc_n1_out_valid", 64'(out_valid), 64'd0);
        chk("abc_checked", 64'(checked_count), 64'd101);
        tick();
        chk("abc_n2_out_valid", 64'(out_valid), 64'd1);
        chk("abc_match", 64'(match_count), 64'd1);
        drain("abc_drain");

        // Stop on first: second match three cycles later is ignored.
        load(ABC_HASH, 1'b1);
        drive(ABC_HASH, ABC_WORD, 64'd24);
        expect_entry(64'h616263, 7'd24);
        tick();
        drive(~ABC_HASH, ABC_WORD, 64'd24);
        chk("sof_n1_state", 64'(state), 64'd1);
        chk("sof_n1_checked", 64'(checked_count), 64'd1);
        tick();
        chk("sof_n2_state", 64'(state), 64'd2);
        chk("sof_n2_checked", 64'(checked_count), 64'd2);
        chk("sof_n2_match", 64'(match_count), 64'd1);
        tick();
        drive(ABC_HASH, 64'h7800000000000000, 64'd8);
        tick();
        hash_valid = 1'b0;
        tick();
        tick();
        chk("sof_frozen_checked", 64'(checked_count), 64'd2);
        chk("sof_frozen_match", 64'(match_count), 64'd1);
        chk("sof_final_state", 64'(state), 64'd2);
        drain("sof_drain");

        // Six back-to-back matches into a depth-4 FIFO with the host stalled.
        out_ready = 1'b0;
        load(ABC_HASH, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(ABC_HASH, {8'hA0 + 8'(i), 56'h0}, 64'd8);
            if (i < 4) begin
                expect_entry(64'hA0 + 64'(i), 7'd8);
            end
            tick();
        end
        hash_valid = 1'b0;
        tick();
        tick();
        chk("ovf_overflow", 64'(overflow), 64'd1);
        chk("ovf_match", 64'(match_count), 64'd6);
        chk("ovf_checked", 64'(checked_count), 64'd6);
        chk("ovf_head_message", out_message, 64'hA0);
        out_ready = 1'b1;
        drain("ovf_drain");

        // Bad length field, then L=0 and L=64 boundaries.
        load(ABC_HASH, 1'b0);
        chk("reload_overflow_clear", 64'(overflow), 64'd0);
        drive(ABC_HASH, ABC_WORD, 64'd65);
        tick();
        hash_valid = 1'b0;
        tick();
        tick();
        chk("bad_flag", 64'(bad_length), 64'd1);
        chk("bad_match", 64'(match_count), 64'd1);
        chk("bad_no_push", 64'(out_valid), 64'd0);
        drive(ABC_HASH, 64'hFFFFFFFFFFFFFFFF, 64'd0);
        expect_entry(64'd0, 7'd0);
        tick();
        drive(ABC_HASH, 64'h0123456789ABCDEF, 64'd64);
        expect_entry(64'h0123456789ABCDEF, 7'd64);
        tick();
        hash_valid = 1'b0;
        tick();
        tick();
        chk("len_match", 64'(match_count), 64'd3);
        drain("len_drain");

        // target_load coincident with a matching result cancels it.
        target_hash   = ABC_HASH;
        stop_on_first = 1'b0;
        target_load   = 1'b1;
        drive(ABC_HASH, ABC_WORD, 64'd24);
        tick();
        target_load = 1'b0;
        hash_valid  = 1'b0;
        chk("tl_checked", 64'(checked_count), 64'd0);
        chk("tl_match", 64'(match_count), 64'd0);
        chk("tl_bad_length", 64'(bad_length), 64'd0);
        chk("tl_state", 64'(state), 64'd1);
        tick();
        tick();
        chk("tl_match_later", 64'(match_count), 64'd0);
        chk("tl_out_valid", 64'(out_valid), 64'd0);

        // Reset with two entries queued and a third match in flight.
        out_ready = 1'b0;
        load(ABC_HASH, 1'b0);
        drive(ABC_HASH, ABC_WORD, 64'd24);
        tick();
        drive(ABC_HASH, 64'h7800000000000000, 64'd8);
        tick();
        hash_valid = 1'b0;
        tick();
        tick();
        chk("prerst_match", 64'(match_count), 64'd2);
        chk("prerst_out_valid", 64'(out_valid), 64'd1);
        drive(ABC_HASH, 64'h5A00000000000000, 64'd8);
        tick();
        hash_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_checked", 64'(checked_count), 64'd0);
        chk("midrst_match", 64'(match_count), 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("postrst_out_valid", 64'(out_valid), 64'd0);
        chk("postrst_state", 64'(state), 64'd0);
        chk("postrst_match", 64'(match_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md5_match_collector.md
# md5_match_collector

Consumes the per-cycle result stream of the MD5 brute-force pipeline (128-bit digest plus the 512-bit padded block that produced it), compares each digest against a host-loaded target, recovers the original candidate message and bit length from the padded block, and queues matches for the host. It sits between the hash pipeline output and the host/UART interface. It also keeps throughput statistics and controls whether the search stops after the first hit.

## Interface
- FIFO_DEPTH, 4, match FIFO entries (power of 2, ≥2)
- CNT_W, 48, width of the checked-digest counter
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- target_load  in  1  pulse: capture target_hash, clear counters, enter ARMED
- target_hash  in  128  digest to search for ({a,b,c,d} order)
- stop_on_first  in  1  sampled with target_load; 1 = go to FOUND after first match
- hash_valid  in  1  hash/block pair valid this cycle
- hash  in  128  digest from pipeline
- block  in  512  padded block paired with hash
- out_valid  out  1  match FIFO non-empty
- out_ready  in  1  host accepts head entry
- out_message  out  64  recovered candidate message, right-aligned
- out_length  out  7  recovered bit length (0..64)
- state  out  2  0 IDLE, 1 ARMED, 2 FOUND
- checked_count  out  CNT_W  digests compared while ARMED
- match_count  out  8  matches detected (saturates at 255)
- overflow  out  1  sticky: match dropped because FIFO full
- bad_length  out  1  sticky: matching block had length field > 64

## Operation
- Reset: state IDLE, out_valid 0, out_message 0, out_length 0, counters 0, overflow 0, bad_length 0, FIFO empty, target 0.
- IDLE: results ignored. target_load → ARMED.
- ARMED: each hash_valid increments checked_count (wraps at 2^CNT_W). Digest equal to target → match.
- Match: recover length L = block[6:0] if block[63:7]==0, else set bad_length, drop entry (still counts in match_count). Message = block[511:448] >> (64−L); L=0 → message 0; L=64 → block[511:448] unshifted. Push {message, L} to FIFO; FIFO full → drop, set overflow.
- stop_on_first=1: first match (valid or bad length) → FOUND. FOUND: no further compares/counting; FIFO drains normally.
- target_load in any state: reload target, clear checked_count, match_count, overflow, bad_length, cancel in-flight stage-1 compare; FIFO contents retained.
- FIFO: push and pop same cycle when full → both succeed, no overflow. Pop only when out_valid & out_ready.

## Timing
- Two-stage: stage 1 registers compare result, L, extracted message (hash_valid at cycle N); stage 2 pushes FIFO at N+1; out_valid high from N+2 when FIFO was empty.
- checked_count updates at N+1. match_count, overflow, bad_length, state transition to FOUND at N+2.
- Compare in stage 1 uses target as of cycle N; target_load at N cancels the compare of cycle N.
- out_message/out_length show FIFO head, held stable while out_valid & !out_ready.
- Back-to-back hash_valid every cycle sustained with no stalls; no backpressure to the pipeline.
- Reset asserted mid-operation: all state returns to reset values immediately; pending matches lost.

## Structure
- Shared md5 package: state encoding, digest/block widths, initial-vector constants, length-field position (block[63:0]).
- One sub-module: md5_match_fifo (parameterised synchronous FIFO, full/empty, simultaneous push/pop).
- Message recovery (shift by 64−L) stays inline as a combinational function.

## Test plan
- Load target = MD5("abc") with stop_on_first=0; feed 100 non-matching pairs then matching block (message 0x616263, L=24) → out_valid at N+2, out_message 0x616263, out_length 24, checked_count 101, match_count 1.
- stop_on_first=1, two matches 3 cycles apart → state FOUND at first match N+2, only one FIFO entry, checked_count frozen after first match.
- Six matches back-to-back with out_ready=0, FIFO_DEPTH 4 → 4 entries held in order, overflow=1, match_count 6; then drain one per cycle, entries preserved.
- Matching block with length field 65 → bad_length=1, no FIFO push; L=0 and L=64 blocks → message 0 and full 64-bit word respectively.
- target_load in same cycle as a matching hash_valid → no match recorded, counters 0 next cycle, state ARMED.
- Assert rst mid-stream with FIFO holding 2 entries → out_valid 0, counters 0, state IDLE, in-flight match not pushed after rst release.
